delay_buffer_prog: RTL and testbench

- Gated, runtime-programmable delay line for complex samples. Intended for the R2SDF FFT stages and the mel-frontend framing path.
- Data advances only on accepted samples (`di_en`), not on every clock.
- Storage is a circular buffer (inferable RAM) rather than a register shift chain.
- Delay length is loaded at run time by `flush`. A fill counter suppresses output until the line holds valid data.

---
 rtl/delay_buffer_prog.sv | 115 +++++++++++
 tb/tb_delay_buffer_prog.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/delay_buffer_prog.sv
// Gated, runtime-programmable delay line for complex samples using a circular RAM buffer.
// Optional macro DELAYBUF_ZERO_FILL_EN: line behaves as if pre-loaded with D zeros.
module delay_buffer_prog #(
  parameter int unsigned MAX_DEPTH = 64,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DLY_W     = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [DLY_W-1:0] delay,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic             primed
);

  localparam int unsigned AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int unsigned EW = 2 * WIDTH;
  localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DEPTH);

  logic [EW-1:0]    mem [MAX_DEPTH];
  logic [EW-1:0]    rd_c;
  logic [DLY_W-1:0] dly_clamp_c;
  logic             accept_c;
  logic             full_c;

  logic [DLY_W-1:0] d_q, d_d;
  logic [DLY_W-1:0] ptr_q, ptr_d;
  logic [DLY_W-1:0] fill_q, fill_d;
  logic             do_en_q, do_en_d;
  logic [WIDTH-1:0] do_re_q, do_re_d;
  logic [WIDTH-1:0] do_im_q, do_im_d;
  logic             primed_q, primed_d;

  assign accept_c = !flush && di_en;
  assign full_c   = (fill_q == d_q);
  assign rd_c     = mem[ptr_q[AW-1:0]];

  // Requested delay clamped into 1..MAX_DEPTH
  always_comb begin
    dly_clamp_c = delay;
    if (delay == '0) begin
      dly_clamp_c = DLY_W'(1);
    end else if (delay > MAX_D) begin
      dly_clamp_c = MAX_D;
    end
  end

  // Next-state and registered output computation
  always_comb begin
    d_d     = d_q;
    ptr_d   = ptr_q;
    fill_d  = fill_q;
    do_en_d = 1'b0;
    do_re_d = do_re_q;
    do_im_d = do_im_q;
    if (flush) begin
      d_d     = dly_clamp_c;
      ptr_d   = '0;
      fill_d  = '0;
      do_re_d = '0;
      do_im_d = '0;
    end else if (di_en) begin
      ptr_d  = (ptr_q == d_q - DLY_W'(1)) ? '0 : ptr_q + DLY_W'(1);
      fill_d = full_c ? fill_q : fill_q + DLY_W'(1);
`ifdef DELAYBUF_ZERO_FILL_EN
      do_en_d            = 1'b1;
      {do_re_d, do_im_d} = full_c ? rd_c : '0;
`else
      if (full_c) begin
        do_en_d            = 1'b1;
        {do_re_d, do_im_d} = rd_c;
      end
`endif
    end
    primed_d = (fill_d == d_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_q      <= MAX_D;
      ptr_q    <= '0;
      fill_q   <= '0;
      do_en_q  <= 1'b0;
      do_re_q  <= '0;
      do_im_q  <= '0;
      primed_q <= 1'b0;
    end else begin
      d_q      <= d_d;
      ptr_q    <= ptr_d;
      fill_q   <= fill_d;
      do_en_q  <= do_en_d;
      do_re_q  <= do_re_d;
      do_im_q  <= do_im_d;
      primed_q <= primed_d;
    end
  end

  // Sample storage; the read above sees the old entry before this write lands
  always_ff @(posedge clock) begin
    if (accept_c) begin
      mem[ptr_q[AW-1:0]] <= {di_re, di_im};
    end
  end

  assign do_en  = do_en_q;
  assign do_re  = do_re_q;
  assign do_im  = do_im_q;
  assign primed = primed_q;

endmodule

// File: tb/tb_delay_buffer_prog.sv
// Scoreboard bench for delay_buffer_prog: queue-based reference line, decoupled output monitor.
module tb_delay_buffer_prog;

  localparam int unsigned MAXD = 64;
  localparam int unsigned W    = 16;
  localparam int unsigned DW   = 7;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic [DW-1:0] delay;
  logic          di_en;
  logic [W-1:0]  di_re, di_im;
  logic          do_en;
  logic [W-1:0]  do_re, do_im;
  logic          primed;

  delay_buffer_prog #(.MAX_DEPTH(MAXD), .WIDTH(W), .DLY_W(DW)) dut (
    .clock(clock), .reset(reset), .flush(flush), .delay(delay),
    .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_en(do_en), .do_re(do_re), .do_im(do_im), .primed(primed)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          edge_no;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] line_q[$];
  int          checks = 0;
  int          failures = 0;
  int          edge_cnt = 0;
  int          model_d = MAXD;
  int          n_acc = 0;
  bit          exp_primed = 1'b0;
  bit          last_flush = 1'b0;

  function automatic int clamp_delay(input int dl);
    if (dl == 0) return 1;
    if (dl > int'(MAXD)) return MAXD;
    return dl;
  endfunction

  // Reference: a queue of held samples; output is whatever falls out the far end
  task automatic model_clear(input int d);
    model_d = d;
    n_acc = 0;
    exp_primed = 1'b0;
    line_q.delete();
`ifdef DELAYBUF_ZERO_FILL_EN
    for (int i = 0; i < d; i++) line_q.push_back(32'h0);
`endif
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at edge %0d", name, act, req, edge_cnt);
    end
  endtask

  // One clock of stimulus, driven at the falling edge
  task automatic step(input bit fl, input int dl, input bit en,
                      input logic [W-1:0] re, input logic [W-1:0] im);
    exp_t e;
    @(negedge clock);
    check("primed", 32'(primed), 32'(exp_primed));
    if (last_flush) begin
      check("flush_do_en", 32'(do_en), 32'h0);
      check("flush_do_data", {do_re, do_im}, 32'h0);
    end
    flush = fl;
    delay = DW'(dl);
    di_en = en;
    di_re = re;
    di_im = im;
    last_flush = fl;
    if (fl) begin
      model_clear(clamp_delay(dl));
    end else if (en) begin
      line_q.push_back({re, im});
      if (n_acc < model_d) n_acc++;
      exp_primed = (n_acc == model_d);
      if (line_q.size() > model_d) begin
        e.edge_no = edge_cnt + 1;
        e.data = line_q.pop_front();
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 16'h0, 16'h0);
  endtask

  // Output monitor: pops the scoreboard whenever the DUT strobes do_en
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      edge_cnt++;
      if (do_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_do_en actual=%h required=no_output at edge %0d", {do_re, do_im}, edge_cnt);
        end else begin
          e = exp_q.pop_front();
          if (e.edge_no != edge_cnt || {do_re, do_im} !== e.data) begin
            failures++;
            $display("FAIL do_data actual=%h@%0d required=%h@%0d", {do_re, do_im}, edge_cnt, e.data, e.edge_no);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
        checks++;
        failures++;
        e = exp_q.pop_front();
        $display("FAIL missing_do_en actual=0 required=%h at edge %0d", e.data, e.edge_no);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    delay = '0;
    di_en = 1'b0;
    di_re = '0;
    di_im = '0;
    repeat (3) @(negedge clock);
    check("reset_do_en", 32'(do_en), 32'h0);
    check("reset_data", {do_re, do_im}, 32'h0);
    check("reset_primed", 32'(primed), 32'h0);
    reset = 1'b1;
    model_clear(MAXD);

    // Delay 4, continuous stream
    step(1'b1, 4, 1'b0, 16'h0, 16'h0);
    for (int k = 1; k <= 20; k++) step(1'b0, 0, 1'b1, 16'(k), 16'($urandom));
    idle(2);

    // Delay 3, toggling enable
    step(1'b1, 3, 1'b0, 16'h0, 16'h0);
    for (int k = 0; k < 10; k++)
      step(1'b0, 0, (k % 2) == 0, 16'(10 * (k / 2 + 1)), 16'(k));
    idle(2);

    // Clamp low and high
    step(1'b1, 0, 1'b0, 16'h0, 16'h0);
    for (int k = 1; k <= 8; k++) step(1'b0, 0, 1'b1, 16'(k + 100), 16'($urandom));
    step(1'b1, 127, 1'b0, 16'h0, 16'h0);
    for (int k = 1; k <= 70; k++) step(1'b0, 0, 1'b1, 16'(k), 16'($urandom));
    idle(2);

    // Flush collides with an accepted sample which must be dropped
    step(1'b1, 5, 1'b0, 16'h0, 16'h0);
    for (int k = 1; k <= 8; k++) step(1'b0, 0, 1'b1, 16'(k + 200), 16'h0);
    step(1'b1, 5, 1'b1, 16'd99, 16'd99);
    for (int k = 1; k <= 8; k++) step(1'b0, 0, 1'b1, 16'(k + 300), 16'h1);
    idle(2);

    // Asynchronous reset pulse between edges while primed
    step(1'b1, 4, 1'b0, 16'h0, 16'h0);
    for (int k = 1; k <= 7; k++) step(1'b0, 0, 1'b1, 16'(k + 400), 16'h2);
    step(1'b0, 0, 1'b0, 16'h0, 16'h0);
    check("pre_reset_primed", 32'(primed), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("async_do_en", 32'(do_en), 32'h0);
    check("async_data", {do_re, do_im}, 32'h0);
    check("async_primed", 32'(primed), 32'h0);
    #1 reset = 1'b1;
    model_clear(MAXD);
    for (int k = 1; k <= 70; k++) step(1'b0, 0, 1'b1, 16'(k + 500), 16'($urandom));
    idle(2);

    // Delay 2 with 7,8,9,10 (zero-fill build also emits the two leading zeros)
    step(1'b1, 2, 1'b0, 16'h0, 16'h0);
    for (int k = 7; k <= 10; k++) step(1'b0, 0, 1'b1, 16'(k), 16'h0);
    idle(2);

    // Randomized traffic with occasional reprogramming flushes
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) step(1'b1, $urandom_range(0, 127), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      else step(1'b0, $urandom_range(0, 127), r < 72, 16'($urandom), 16'($urandom));
    end
    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
